// File: rtl/mem_arbiter.sv
// Purpose : shares one single-ported, variable-latency memory between IF and MEM; data has fixed priority over fetch.
// Latency : a request seen in IDLE raises mem_req_o on the next cycle; an ack in that cycle releases stall_o combinationally.
// Backpr. : stall_o freezes the whole pipeline until every pending request has completed; a timeout completes a stuck access.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   MemRead_i, MemWrite_i, d_addr_i,
//   d_wdata_i                         data request from EX/MEM (write wins when both are set)
//   if_req_i, if_addr_i               fetch request from IF
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_ack_i,
//   mem_rdata_i                       memory request/acknowledge handshake
//   d_rdata_o, if_rdata_o             load data to MEM/WB, instruction to IF/ID
//   stall_o                           freeze PC and pipeline registers
//   err_o                             sticky timeout flag
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] d_rdata_o,
    output logic [31:0] if_rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          d_done_q,  d_done_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          err_q,     err_d;
    logic          we_q,      we_d;
    logic [31:0]   addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;

    logic dreq, d_pend, d_busy, i_busy, busy, tmo, cmp, stall;

    always_comb begin
        dreq   = MemRead_i | MemWrite_i;
        // d_done_q masks a data request that already completed while a fetch kept the pipeline frozen
        d_pend = dreq & ~d_done_q;
        d_busy = (state_q == D_BUSY);
        i_busy = (state_q == I_BUSY);
        busy   = d_busy | i_busy;
        tmo    = busy & (cnt_q == CNT_LAST);
        cmp    = busy & (mem_ack_i | tmo);
        stall  = (d_pend & ~(d_busy & cmp)) | (if_req_i & ~(i_busy & cmp));
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d = D_BUSY;
                    we_d    = MemWrite_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                end else if (if_req_i) begin
                    state_d = I_BUSY;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = 32'd0;
                end
            end
            D_BUSY, I_BUSY: begin
                if (cmp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timed-out load returns zero; stores never disturb the held load data
        if (d_busy & cmp & ~we_q) begin
            d_rdata_d = mem_ack_i ? mem_rdata_i : 32'd0;
        end

        cnt_d    = (busy & ~cmp) ? cnt_q + CW'(1) : '0;
        err_d    = err_q | (tmo & ~mem_ack_i);
        d_done_d = stall ? (d_done_q | (d_busy & cmp)) : 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            d_done_q  <= 1'b0;
            d_rdata_q <= 32'd0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    // Bypass in the ack cycle so the pipeline can advance at the end of it
    assign d_rdata_o   = (d_busy & mem_ack_i) ? mem_rdata_i : d_rdata_q;
    assign if_rdata_o  = (i_busy & mem_ack_i) ? mem_rdata_i : 32'd0;
    assign stall_o     = stall;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed, table-driven bench for mem_arbiter (TIMEOUT = 4).
// Latency : one vector per clock; inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : memory ack timing is scripted in each vector.
module tb_mem_arbiter;

    localparam int TMO = 4;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] d_rdata_o, if_rdata_o;
    logic        stall_o, err_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .d_rdata_o   (d_rdata_o),
        .if_rdata_o  (if_rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    typedef struct {
        bit          rst, rd, wr;
        logic [31:0] d_addr, d_wdata;
        bit          if_req;
        logic [31:0] if_addr;
        bit          ack;
        logic [31:0] rdata;
        bit          chk_all;   // also check latched request fields while idle
        bit          e_req, e_we;
        logic [31:0] e_addr, e_wdata, e_drd, e_ird;
        bit          e_stall, e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    endtask

    function automatic void add(input vec_t v);
        tbl.push_back(v);
    endfunction

    // Entered 1 unit after a rising edge; leaves 1 unit after the next one.
    task automatic apply(input vec_t v, input int idx);
        rst_i       = v.rst;
        MemRead_i   = v.rd;
        MemWrite_i  = v.wr;
        d_addr_i    = v.d_addr;
        d_wdata_i   = v.d_wdata;
        if_req_i    = v.if_req;
        if_addr_i   = v.if_addr;
        mem_ack_i   = v.ack;
        mem_rdata_i = v.rdata;
        @(negedge clk_i);
        check("mem_req", idx, {31'd0, mem_req_o}, {31'd0, v.e_req});
        check("stall",   idx, {31'd0, stall_o},   {31'd0, v.e_stall});
        check("err",     idx, {31'd0, err_o},     {31'd0, v.e_err});
        check("d_rdata", idx, d_rdata_o,  v.e_drd);
        check("if_rdata", idx, if_rdata_o, v.e_ird);
        if (v.e_req || v.chk_all) begin
            check("mem_we",    idx, {31'd0, mem_we_o}, {31'd0, v.e_we});
            check("mem_addr",  idx, mem_addr_o,  v.e_addr);
            check("mem_wdata", idx, mem_wdata_o, v.e_wdata);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //   rst rd wr d_addr   d_wdata  ifr if_addr  ack rdata   chk   req we addr    wdata    d_rdata  if_rdata  stall err
        add('{Y, N, N, 32'h0,  32'h0,  N, 32'h0,   N, 32'h0,       Y, N, N, 32'h0,   32'h0, 32'h0,        32'h0,        N, N}); // reset held
        add('{N, N, N, 32'h0,  32'h0,  N, 32'h0,   N, 32'h0,       Y, N, N, 32'h0,   32'h0, 32'h0,        32'h0,        N, N}); // idle after reset
        // fetch only, ack in first busy cycle
        add('{N, N, N, 32'h0,  32'h0,  Y, 32'h100, N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'h0,        32'h0,        Y, N});
        add('{N, N, N, 32'h0,  32'h0,  Y, 32'h100, Y, 32'h8C220004,N, Y, N, 32'h100, 32'h0, 32'h0,        32'h8C220004, N, N});
        add('{N, N, N, 32'h0,  32'h0,  N, 32'h0,   Y, 32'hFFFFFFFF,N, N, N, 32'h0,   32'h0, 32'h0,        32'h0,        N, N}); // stray ack ignored
        // load plus fetch, 3-cycle latency each
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'h0,        32'h0,        Y, N});
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, Y, N, 32'h40,  32'h0, 32'h0,        32'h0,        Y, N});
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, Y, N, 32'h40,  32'h0, 32'h0,        32'h0,        Y, N});
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, Y, 32'hDEADBEEF,N, Y, N, 32'h40,  32'h0, 32'hDEADBEEF, 32'h0,        Y, N});
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'hDEADBEEF, 32'h0,        Y, N}); // gap cycle
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, Y, N, 32'h104, 32'h0, 32'hDEADBEEF, 32'h0,        Y, N}); // fetch, load not reissued
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, N, 32'h0,       N, Y, N, 32'h104, 32'h0, 32'hDEADBEEF, 32'h0,        Y, N});
        add('{N, Y, N, 32'h40, 32'h0,  Y, 32'h104, Y, 32'h00000013,N, Y, N, 32'h104, 32'h0, 32'hDEADBEEF, 32'h00000013, N, N});
        add('{N, N, N, 32'h0,  32'h0,  N, 32'h0,   N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'hDEADBEEF, 32'h0,        N, N});
        // store
        add('{N, N, Y, 32'h80, 32'h12345678, N, 32'h0, N, 32'h0,       N, N, N, 32'h0,  32'h0,        32'hDEADBEEF, 32'h0, Y, N});
        add('{N, N, Y, 32'h80, 32'h12345678, N, 32'h0, N, 32'h0,       N, Y, Y, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h0, Y, N});
        add('{N, N, Y, 32'h80, 32'h12345678, N, 32'h0, Y, 32'hAAAA5555,N, Y, Y, 32'h80, 32'h12345678, 32'hAAAA5555, 32'h0, N, N});
        add('{N, N, N, 32'h0,  32'h0,        N, 32'h0, N, 32'h0,       N, N, N, 32'h0,  32'h0,        32'hDEADBEEF, 32'h0, N, N});
        // read+write together is a write
        add('{N, Y, Y, 32'h90, 32'h55, N, 32'h0,   N, 32'h0,       N, N, N, 32'h0,   32'h0,  32'hDEADBEEF, 32'h0,        Y, N});
        add('{N, Y, Y, 32'h90, 32'h55, N, 32'h0,   Y, 32'h77,      N, Y, Y, 32'h90,  32'h55, 32'h77,       32'h0,        N, N});
        add('{N, N, N, 32'h0,  32'h0,  N, 32'h0,   N, 32'h0,       N, N, N, 32'h0,   32'h0,  32'hDEADBEEF, 32'h0,        N, N});
        // minimum-latency load
        add('{N, Y, N, 32'h44, 32'h0,  N, 32'h0,   N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'hDEADBEEF, 32'h0,        Y, N});
        add('{N, Y, N, 32'h44, 32'h0,  N, 32'h0,   Y, 32'h0BADF00D,N, Y, N, 32'h44,  32'h0, 32'h0BADF00D, 32'h0,        N, N});
        add('{N, N, N, 32'h0,  32'h0,  N, 32'h0,   N, 32'h0,       N, N, N, 32'h0,   32'h0, 32'h0BADF00D, 32'h0,        N, N});

        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        if_req_i = 1'b0; if_addr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        @(posedge clk_i);
        #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Timeout: load with no ack; four busy cycles, stall released in the fourth
        apply('{N, Y, N, 32'h48, 32'h0, N, 32'h0, N, 32'h0, N, N, N, 32'h0,  32'h0, 32'h0BADF00D, 32'h0, Y, N}, 100);
        for (int k = 1; k < TMO; k++)
            apply('{N, Y, N, 32'h48, 32'h0, N, 32'h0, N, 32'h0, N, Y, N, 32'h48, 32'h0, 32'h0BADF00D, 32'h0, Y, N}, 100 + k);
        apply('{N, Y, N, 32'h48, 32'h0, N, 32'h0, N, 32'h0, N, Y, N, 32'h48, 32'h0, 32'h0BADF00D, 32'h0, N, N}, 104);
        apply('{N, N, N, 32'h0,  32'h0, N, 32'h0, N, 32'h0, N, N, N, 32'h0,  32'h0, 32'h0,        32'h0, N, Y}, 105);
        apply('{N, N, N, 32'h0,  32'h0, N, 32'h0, N, 32'h0, N, N, N, 32'h0,  32'h0, 32'h0,        32'h0, N, Y}, 106);

        // Reset mid-access: reset on 2nd busy cycle, late ack ignored, load reissued afterwards
        apply('{Y, N, N, 32'h0,  32'h0, N, 32'h0, N, 32'h0,  N, N, N, 32'h0,  32'h0, 32'h0,  32'h0, N, Y}, 200);
        apply('{N, Y, N, 32'h4C, 32'h0, N, 32'h0, N, 32'h0,  N, N, N, 32'h0,  32'h0, 32'h0,  32'h0, Y, N}, 201);
        apply('{N, Y, N, 32'h4C, 32'h0, N, 32'h0, N, 32'h0,  N, Y, N, 32'h4C, 32'h0, 32'h0,  32'h0, Y, N}, 202);
        apply('{Y, Y, N, 32'h4C, 32'h0, N, 32'h0, N, 32'h0,  N, Y, N, 32'h4C, 32'h0, 32'h0,  32'h0, Y, N}, 203);
        apply('{N, Y, N, 32'h4C, 32'h0, N, 32'h0, Y, 32'h99, N, N, N, 32'h0,  32'h0, 32'h0,  32'h0, Y, N}, 204);
        apply('{N, Y, N, 32'h4C, 32'h0, N, 32'h0, N, 32'h0,  N, Y, N, 32'h4C, 32'h0, 32'h0,  32'h0, Y, N}, 205);
        apply('{N, Y, N, 32'h4C, 32'h0, N, 32'h0, Y, 32'h31, N, Y, N, 32'h4C, 32'h0, 32'h31, 32'h0, N, N}, 206);
        apply('{N, N, N, 32'h0,  32'h0, N, 32'h0, N, 32'h0,  N, N, N, 32'h0,  32'h0, 32'h31, 32'h0, N, N}, 207);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
